seg_scan_decoder: RTL and testbench
===================================

SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 SHALL have parameter STABLE, default 4: consecutive sampled cycles a select/pattern pair must hold before commit (legal range 2..255).
REQ-002 SHALL have parameter TIMEOUT, default 20000: cycles without any commit before stale asserts (legal range 16..2^20-1).
REQ-003 SHALL have port ck, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset is asynchronous and active-low.
REQ-005 SHALL have port seg, input, 8 bits: segment lines, active-high, bit0=a … bit6=g, bit7=dp.
REQ-006 SHALL have port ctrl, input, 6 bits: digit selects, active-low, one-cold; ctrl[i]=0 selects digit i.
REQ-007 SHALL have port val, output, 24 bits: decoded hex value of digit i in val[4i+3:4i].
REQ-008 SHALL have port dp, output, 6 bits: decimal-point state of digit i.
REQ-009 SHALL have port blank, output, 6 bits: digit i last committed with seg[6:0]=0.
REQ-010 SHALL have port bad, output, 6 bits: digit i last committed with an undecodable pattern.
REQ-011 SHALL have port frame_done, output, 1 bit: one-cycle pulse when all six digits have committed since the previous pulse.
REQ-012 SHALL have port sel_err, output, 1 bit: one-cycle pulse per sampled cycle in which two or more ctrl bits are low.
REQ-013 SHALL have port stale, output, 1 bit: high while no commit has occurred for TIMEOUT cycles.

Function
REQ-014 SHALL register seg and ctrl in one input stage; all decisions use the registered copies.
REQ-015 SHALL decode seg[6:0] with standard hex patterns: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F, A=0x77, b=0x7C, C=0x39, d=0x5E, E=0x79, F=0x71.
REQ-016 SHALL treat seg[6:0]=0x00 as blank (val nibble 0, blank=1, bad=0); any other non-table pattern gives val nibble 0, blank=0, bad=1.
REQ-017 SHALL implement states IDLE, SETTLE, HELD.
- IDLE: registered ctrl is all-high or multi-low.
- SETTLE: a one-cold select is present; a counter counts matching cycles.
- HELD: the current pair has been committed.
REQ-018 Transitions:
- IDLE→SETTLE when the registered ctrl is one-cold, with the counter set to 1.
- SETTLE→SETTLE with counter+1 while the pair (ctrl, seg) is unchanged.
- On any pair change: SETTLE or HELD→SETTLE with counter=1 if the new ctrl is one-cold, else →IDLE.
REQ-019 SHALL commit when the counter reaches STABLE: write val/dp/blank/bad for the selected digit, then enter HELD; exactly one commit per dwell.
REQ-020 Latency: a pair first present on the inputs before edge N SHALL appear on the outputs after edge N+STABLE.
REQ-021 SHALL keep a 6-bit seen mask, setting bit i on commit to digit i. When the mask becomes all ones, frame_done SHALL pulse in the same cycle the outputs update, and the mask SHALL clear.
REQ-022 SHALL re-commit the same digit within a frame by overwriting its outputs; this does not affect frame_done.
REQ-023 SHALL pulse sel_err on every multi-low sampled cycle and SHALL never commit while multi-low.
REQ-024 SHALL reset the timeout counter on every commit and saturate it at TIMEOUT.
- stale SHALL assert when the counter reaches TIMEOUT.
- stale SHALL deassert on the cycle after the next commit.
- Digit outputs SHALL hold their values while stale.
REQ-025 SHALL keep the outputs of uncommitted digits at their previous values.

Reset
REQ-026 While reset=0:
- val, dp, blank, bad, frame_done, sel_err, stale, the seen mask and all counters SHALL be 0.
- The state SHALL be IDLE.
- The input registers SHALL be seg=0x00 and ctrl=6'h3F.
REQ-027 Reset assertion mid-SETTLE SHALL discard the partial dwell; after release, a pair SHALL need a full STABLE cycles to commit.

Verification
REQ-028 Drive ctrl=6'b111110, seg=0x4F for 4 cycles → after edge 5: val[3:0]=3, blank[0]=0, bad[0]=0; no second commit while held.
REQ-029 Scan digits 0..5 with 0x3F, 0x06, 0x5B, 0x4F, 0x66, 0xED, 6 cycles each → val=24'h543210, dp=6'b100000, one frame_done pulse on the digit-5 commit.
REQ-030 Drive ctrl=6'b111101 with seg=0x07 for 3 cycles, then seg=0x77 for 4 cycles → digit 1 commits A only; 7 is never visible.
REQ-031 Drive ctrl=6'b111100 for 10 cycles → sel_err high on 10 consecutive cycles; no output changes.
REQ-032 Drive seg=0x00, then seg=0x01 on digit 2 → blank[2]=1 then bad[2]=1, val[11:8]=0 both times.
REQ-033 With TIMEOUT=16, hold ctrl=6'h3F after a commit → stale rises 16 cycles after the commit; the next valid dwell clears it. Pulse reset mid-dwell → all outputs 0 and a fresh STABLE dwell is required.

Source files
------------

// File: rtl/seg_scan_decoder.sv
// Seven-segment scan decoder: samples a multiplexed display bus, waits for each
// digit select/pattern pair to stay stable, then latches the decoded hex value,
// decimal point and blank/bad flags for that digit. It also flags frame
// completion, multi-select glitches and a stale (no-update) condition.
module seg_scan_decoder #(
   parameter int STABLE  = 4,
   parameter int TIMEOUT = 20000
) (
   input  logic        ck,
   input  logic        reset,
   input  logic [7:0]  seg,
   input  logic [5:0]  ctrl,
   output logic [23:0] val,
   output logic [5:0]  dp,
   output logic [5:0]  blank,
   output logic [5:0]  bad,
   output logic        frame_done,
   output logic        sel_err,
   output logic        stale
);

   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;

   logic [7:0]    r_seg, r_pseg;
   logic [5:0]    r_ctrl, r_pctrl;
   state_t        r_state;
   logic [7:0]    r_cnt;
   logic [TW-1:0] r_tcnt;
   logic [5:0]    r_seen;
   logic [23:0]   r_val;
   logic [5:0]    r_dp, r_blank, r_bad;
   logic          r_frame_done, r_sel_err, r_stale;

   logic [2:0]    w_nz;
   logic [2:0]    w_idx;
   logic          w_onecold, w_multi, w_same, w_commit;
   logic [5:0]    w_dec;
   logic [5:0]    w_seen_nxt;

   // Map a 7-segment pattern to {blank, bad, nibble}.
   function automatic logic [5:0] dec7(input logic [6:0] s);
      case (s)
         7'h3F: dec7 = 6'h00;
         7'h06: dec7 = 6'h01;
         7'h5B: dec7 = 6'h02;
         7'h4F: dec7 = 6'h03;
         7'h66: dec7 = 6'h04;
         7'h6D: dec7 = 6'h05;
         7'h7D: dec7 = 6'h06;
         7'h07: dec7 = 6'h07;
         7'h7F: dec7 = 6'h08;
         7'h6F: dec7 = 6'h09;
         7'h77: dec7 = 6'h0A;
         7'h7C: dec7 = 6'h0B;
         7'h39: dec7 = 6'h0C;
         7'h5E: dec7 = 6'h0D;
         7'h79: dec7 = 6'h0E;
         7'h71: dec7 = 6'h0F;
         7'h00: dec7 = 6'h20;
         default: dec7 = 6'h10;
      endcase
   endfunction

   // Input stage: every decision below looks only at these registered copies.
   always_ff @(posedge ck or negedge reset) begin
      if (!reset) begin
         r_seg  <= 8'h00;
         r_ctrl <= 6'h3F;
      end else begin
         r_seg  <= seg;
         r_ctrl <= ctrl;
      end
   end

   // Count low select lines and locate the selected digit.
   always_comb begin
      w_nz  = 3'd0;
      w_idx = 3'd0;
      for (int i = 0; i < 6; i++) begin
         if (!r_ctrl[i]) begin
            w_nz  = w_nz + 3'd1;
            w_idx = 3'(i);
         end
      end
   end

   assign w_onecold  = (w_nz == 3'd1);
   assign w_multi    = (w_nz >= 3'd2);
   assign w_same     = (r_ctrl == r_pctrl) && (r_seg == r_pseg);
   // Commit on the cycle the dwell counter would reach STABLE.
   assign w_commit   = (r_state == SETTLE) && w_same && (r_cnt == 8'(STABLE - 1));
   assign w_dec      = dec7(r_seg[6:0]);
   assign w_seen_nxt = r_seen | (6'd1 << w_idx);

   // Dwell FSM: tracks the current pair and how long it has been stable.
   always_ff @(posedge ck or negedge reset) begin
      if (!reset) begin
         r_state <= IDLE;
         r_cnt   <= 8'd0;
         r_pseg  <= 8'h00;
         r_pctrl <= 6'h3F;
      end else begin
         r_pseg  <= r_seg;
         r_pctrl <= r_ctrl;
         if (r_state != IDLE && w_same) begin
            if (r_state == SETTLE) begin
               r_cnt <= r_cnt + 8'd1;
               if (w_commit) r_state <= HELD;
            end
         end else if (w_onecold) begin
            r_state <= SETTLE;
            r_cnt   <= 8'd1;
         end else begin
            r_state <= IDLE;
            r_cnt   <= 8'd0;
         end
      end
   end

   // Digit outputs and frame tracking; uncommitted digits keep their values.
   always_ff @(posedge ck or negedge reset) begin
      if (!reset) begin
         r_val        <= 24'h0;
         r_dp         <= 6'h0;
         r_blank      <= 6'h0;
         r_bad        <= 6'h0;
         r_seen       <= 6'h0;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= 1'b0;
         for (int i = 0; i < 6; i++) begin
            if (w_commit && w_idx == 3'(i)) begin
               r_val[4*i +: 4] <= w_dec[3:0];
               r_dp[i]         <= r_seg[7];
               r_blank[i]      <= w_dec[5];
               r_bad[i]        <= w_dec[4];
            end
         end
         if (w_commit) begin
            if (w_seen_nxt == 6'h3F) begin
               r_seen       <= 6'h0;
               r_frame_done <= 1'b1;
            end else begin
               r_seen <= w_seen_nxt;
            end
         end
      end
   end

   // Select-glitch pulse and no-commit watchdog.
   always_ff @(posedge ck or negedge reset) begin
      if (!reset) begin
         r_sel_err <= 1'b0;
         r_tcnt    <= '0;
         r_stale   <= 1'b0;
      end else begin
         r_sel_err <= w_multi;
         if (w_commit)
            r_tcnt <= '0;
         else if (r_tcnt != TW'(TIMEOUT))
            r_tcnt <= r_tcnt + 1'b1;
         r_stale <= !w_commit && (r_tcnt >= TW'(TIMEOUT - 1));
      end
   end

   assign val        = r_val;
   assign dp         = r_dp;
   assign blank      = r_blank;
   assign bad        = r_bad;
   assign frame_done = r_frame_done;
   assign sel_err    = r_sel_err;
   assign stale      = r_stale;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder (STABLE=4, TIMEOUT=16).
module tb_seg_scan_decoder;

   logic        ck = 1'b0;
   logic        reset = 1'b0;
   logic [7:0]  seg = 8'h00;
   logic [5:0]  ctrl = 6'h3F;
   logic [23:0] val;
   logic [5:0]  dp, blank, bad;
   logic        frame_done, sel_err, stale;

   int checks = 0;
   int errors = 0;

   logic [7:0] scan_seg [6] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'hED};

   seg_scan_decoder #(.STABLE(4), .TIMEOUT(16)) dut (
      .ck(ck), .reset(reset), .seg(seg), .ctrl(ctrl), .val(val), .dp(dp),
      .blank(blank), .bad(bad), .frame_done(frame_done), .sel_err(sel_err),
      .stale(stale)
   );

   always #5 ck = ~ck;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge ck);
      #1;
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   initial begin
      // Reset state
      #2;
      chk("rst_val", val, 24'h0);
      chk("rst_dp", dp, 6'h0);
      chk("rst_blank", blank, 6'h0);
      chk("rst_bad", bad, 6'h0);
      chk("rst_flags", {frame_done, sel_err, stale}, 3'b000);
      tick();
      reset = 1'b1;

      // Single digit commit and latency
      ctrl = 6'b111110; seg = 8'h4F;
      ticks(4);
      chk("lat_early", val[3:0], 4'h0);
      tick();
      chk("lat_val", val[3:0], 4'h3);
      chk("lat_flags", {blank[0], bad[0]}, 2'b00);

      // Hold, then go idle; stale must rise exactly 16 cycles after the commit
      ticks(10);
      ctrl = 6'h3F;
      ticks(5);
      chk("stale_early", stale, 1'b0);
      tick();
      chk("stale_rise", stale, 1'b1);
      chk("stale_hold", val[3:0], 4'h3);

      // Full frame scan
      for (int d = 0; d < 6; d++) begin
         ctrl = ~(6'd1 << d);
         seg  = scan_seg[d];
         for (int t = 1; t <= 6; t++) begin
            tick();
            chk("scan_frame_done", frame_done, (d == 5 && t == 5));
            chk("scan_stale", stale, (d == 0 && t < 5));
         end
      end
      chk("scan_val", val, 24'h543210);
      chk("scan_dp", dp, 6'b100000);

      // Short dwell of 7 then A on digit 1
      ctrl = 6'b111101; seg = 8'h07;
      ticks(3);
      chk("glitch_hold", val[7:4], 4'h1);
      seg = 8'h77;
      ticks(4);
      chk("glitch_pre", val[7:4], 4'h1);
      tick();
      chk("glitch_val", val, 24'h5432A0);

      // Multi-low select
      ctrl = 6'b111100; seg = 8'h7F;
      for (int i = 1; i <= 12; i++) begin
         tick();
         chk("sel_err", sel_err, (i >= 2 && i <= 11));
         if (i == 10) ctrl = 6'h3F;
      end
      chk("sel_val", val, 24'h5432A0);
      chk("sel_flags", {blank, bad}, 12'h0);

      // Blank then bad on digit 2
      ctrl = 6'b111011; seg = 8'h00;
      ticks(6);
      chk("blank_flags", {blank[2], bad[2]}, 2'b10);
      chk("blank_val", val, 24'h5430A0);
      seg = 8'h01;
      ticks(6);
      chk("bad_flags", {blank[2], bad[2]}, 2'b01);
      chk("bad_val", val, 24'h5430A0);

      // Reset mid-dwell on digit 3
      ctrl = 6'b110111; seg = 8'h06;
      ticks(3);
      reset = 1'b0;
      #1;
      chk("mid_rst_val", val, 24'h0);
      chk("mid_rst_bits", {dp, blank, bad}, 18'h0);
      chk("mid_rst_flags", {frame_done, sel_err, stale}, 3'b000);
      ticks(2);
      reset = 1'b1;
      ticks(4);
      chk("mid_rst_early", val, 24'h0);
      tick();
      chk("mid_rst_commit", val, 24'h001000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
